// File: rtl/frac_search_ctrl.sv
// frac_search_ctrl
// Sequencer for the 8x8 quarter-pel search datapath. For each block it feeds
// the eight row indices to the row buffers and datapath under a valid/ready
// handshake, sums the six per-row candidate SADs into whole-block totals,
// walks a sequential minimum comparator over the six totals and reports the
// winner with a one-cycle done pulse.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low; clears all state
//   start      in   begin a block search (sampled only when idle)
//   row_ready  in   datapath accepts the presented row this cycle
//   sad_valid  in   sad_in carries the six SADs of one row
//   sad_in     in   candidate k SAD on bits [10k+9:10k], unsigned
//   row_valid  out  row_addr is being presented
//   row_addr   out  row index 0..7
//   busy       out  high whenever the sequencer is not idle
//   done       out  one-cycle pulse, best_idx/best_sad valid
//   best_idx   out  winning candidate index 0..5
//   best_sad   out  block SAD of the winner
module frac_search_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        row_ready,
  input  logic        sad_valid,
  input  logic [59:0] sad_in,
  output logic        row_valid,
  output logic [2:0]  row_addr,
  output logic        busy,
  output logic        done,
  output logic [2:0]  best_idx,
  output logic [12:0] best_sad
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CMP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]  state_r;
  logic [2:0]  next_state_s;
  logic [2:0]  row_cnt_r;
  logic [3:0]  sad_cnt_r;
  logic [3:0]  sad_cnt_next_s;
  logic [2:0]  cmp_k_r;
  logic [12:0] acc_r [6];
  logic [12:0] cand_s;
  logic        sad_take_s;
  logic        accept_s;
  logic        row_valid_r;
  logic        busy_r;
  logic        done_r;
  logic [2:0]  best_idx_r;
  logic [12:0] best_sad_r;

  assign row_valid = row_valid_r;
  assign row_addr  = row_cnt_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign best_idx  = best_idx_r;
  assign best_sad  = best_sad_r;

  // Handshake qualifiers: row accept and which sad_valid pulses count.
  always_comb begin
    accept_s   = (state_r == ST_FETCH) && row_ready;
    // SADs only count while a block is collecting and fewer than 8 have landed.
    sad_take_s = sad_valid && ((state_r == ST_FETCH) || (state_r == ST_WAIT))
                 && (sad_cnt_r < 4'd8);
    if (sad_take_s) begin
      sad_cnt_next_s = sad_cnt_r + 4'd1;
    end else begin
      sad_cnt_next_s = sad_cnt_r;
    end
  end

  // Comparator operand mux: the accumulator addressed by the compare step.
  always_comb begin
    cand_s = 13'd0;
    case (cmp_k_r)
      3'd0:    cand_s = acc_r[0];
      3'd1:    cand_s = acc_r[1];
      3'd2:    cand_s = acc_r[2];
      3'd3:    cand_s = acc_r[3];
      3'd4:    cand_s = acc_r[4];
      3'd5:    cand_s = acc_r[5];
      default: cand_s = 13'd0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) next_state_s = ST_FETCH;
        else       next_state_s = ST_IDLE;
      end
      ST_FETCH: begin
        // The last row accept may coincide with the 8th SAD (zero latency).
        if (accept_s && (row_cnt_r == 3'd7)) begin
          if (sad_cnt_next_s == 4'd8) next_state_s = ST_CMP;
          else                        next_state_s = ST_WAIT;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (sad_cnt_next_s == 4'd8) next_state_s = ST_CMP;
        else                        next_state_s = ST_WAIT;
      end
      ST_CMP: begin
        if (cmp_k_r == 3'd5) next_state_s = ST_DONE;
        else                 next_state_s = ST_CMP;
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, counters, accumulators, comparator and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      row_cnt_r   <= 3'd0;
      sad_cnt_r   <= 4'd0;
      cmp_k_r     <= 3'd0;
      row_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      best_idx_r  <= 3'd0;
      best_sad_r  <= 13'd0;
      for (int k = 0; k < 6; k++) acc_r[k] <= 13'd0;
    end else begin
      state_r <= next_state_s;
      // Outputs are decoded from the next state so they appear registered.
      row_valid_r <= (next_state_s == ST_FETCH);
      busy_r      <= (next_state_s != ST_IDLE);
      done_r      <= (next_state_s == ST_DONE);

      if ((state_r == ST_IDLE) && start) begin
        row_cnt_r <= 3'd0;
        sad_cnt_r <= 4'd0;
        cmp_k_r   <= 3'd0;
        for (int k = 0; k < 6; k++) acc_r[k] <= 13'd0;
      end else begin
        if (accept_s) row_cnt_r <= row_cnt_r + 3'd1;
        if (sad_take_s) begin
          // 8 * 1023 = 8184 fits in 13 bits, so plain addition never wraps.
          for (int k = 0; k < 6; k++) begin
            acc_r[k] <= acc_r[k] + {3'b000, sad_in[10*k +: 10]};
          end
          sad_cnt_r <= sad_cnt_next_s;
        end
        if (state_r == ST_CMP) begin
          if (cmp_k_r == 3'd5) cmp_k_r <= 3'd0;
          else                 cmp_k_r <= cmp_k_r + 3'd1;
          if (cmp_k_r == 3'd0) begin
            best_sad_r <= cand_s;
            best_idx_r <= 3'd0;
          end else if (cand_s < best_sad_r) begin
            // Strict compare: ties keep the lower index.
            best_sad_r <= cand_s;
            best_idx_r <= cmp_k_r;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_frac_search_ctrl.sv
module tb_frac_search_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        row_ready;
  logic        sad_valid;
  logic [59:0] sad_in;
  logic        row_valid;
  logic [2:0]  row_addr;
  logic        busy;
  logic        done;
  logic [2:0]  best_idx;
  logic [12:0] best_sad;

  int errors = 0;
  int checks = 0;

  frac_search_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .row_ready(row_ready),
    .sad_valid(sad_valid), .sad_in(sad_in), .row_valid(row_valid),
    .row_addr(row_addr), .busy(busy), .done(done),
    .best_idx(best_idx), .best_sad(best_sad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [59:0] pack6(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5);
    return {10'(a5), 10'(a4), 10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  // Runs one block search. Cycle 0 is the cycle in which start is driven high.
  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic run_search(
    input  logic [59:0] sads, input int lat, input int stall_a, input int stall_b,
    input  int start_cyc, input int spur_cyc, input int abort_cyc,
    input  logic chained, input logic hold_start_done, input logic chain_next,
    output int done_cyc, output int vcount, output logic addr_ok,
    output logic [2:0] idx, output logic [12:0] bsad, output logic post_ok);
    int acc_cyc[$];
    int nsad;
    logic [2:0] exp_addr;
    logic ready;
    done_cyc = -1; vcount = 0; addr_ok = 1'b1; idx = 3'd0; bsad = 13'd0;
    post_ok = 1'b0; nsad = 0; exp_addr = 3'd0;
    if (!chained) @(negedge clk);
    start = 1'b1; row_ready = 1'b1; sad_valid = 1'b0; sad_in = 60'd0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = (c == start_cyc);
      if (c == abort_cyc) begin
        reset = 1'b0;
        break;
      end
      if (done) begin
        done_cyc = c; idx = best_idx; bsad = best_sad;
        start = hold_start_done; sad_valid = 1'b0;
        break;
      end
      if (row_valid) begin
        vcount++;
        if (row_addr !== exp_addr) addr_ok = 1'b0;
      end
      ready = !((c == stall_a) || (c == stall_b));
      row_ready = ready;
      if (row_valid && ready) begin
        acc_cyc.push_back(c);
        exp_addr = exp_addr + 3'd1;
      end
      sad_valid = 1'b0; sad_in = 60'd0;
      if ((nsad < acc_cyc.size()) && (acc_cyc[nsad] + lat == c)) begin
        sad_valid = 1'b1; sad_in = sads; nsad++;
      end else if (c == spur_cyc) begin
        sad_valid = 1'b1; sad_in = {6{10'd1023}};
      end
    end
    if (done_cyc >= 0) begin
      @(negedge clk);
      start = chain_next;
      post_ok = (done === 1'b0) && (busy === 1'b0) && (best_idx === idx) && (best_sad === bsad);
    end
  endtask

  task automatic test_reset();
    int dc, vc; logic ok, pk; logic [2:0] ix; logic [12:0] bs;
    reset = 1'b0; start = 1'b0; row_ready = 1'b0; sad_valid = 1'b0; sad_in = 60'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({row_valid, row_addr, busy, done, best_idx, best_sad} !== 22'd0) begin
      errors++; $display("FAIL reset_hold outputs=%h required 0", {row_valid, row_addr, busy, done, best_idx, best_sad});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({row_valid, row_addr, busy, done, best_idx, best_sad} !== 22'd0) begin
      errors++; $display("FAIL reset_release outputs=%h required 0", {row_valid, row_addr, busy, done, best_idx, best_sad});
    end
    run_search(pack6(10, 11, 12, 13, 14, 15), 0, -1, -1, -1, -1, -1, 1'b0, 1'b0, 1'b0, dc, vc, ok, ix, bs, pk);
    checks++; if (dc !== 15) begin errors++; $display("FAIL basic_done_cycle got %0d required 15", dc); end
    checks++; if (ix !== 3'd0) begin errors++; $display("FAIL basic_idx got %0d required 0", ix); end
    checks++; if (bs !== 13'd80) begin errors++; $display("FAIL basic_sad got %0d required 80", bs); end
    checks++; if (vc !== 8) begin errors++; $display("FAIL basic_row_valid_cycles got %0d required 8", vc); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_row_addr got bad sequence required 0..7"); end
    checks++; if (pk !== 1'b1) begin errors++; $display("FAIL basic_after_done got %0b required done=0 busy=0 results held", pk); end
  endtask

  task automatic test_backpressure();
    int dc, vc; logic ok, pk; logic [2:0] ix; logic [12:0] bs;
    run_search(pack6(10, 11, 12, 13, 14, 15), 0, 3, 4, -1, -1, -1, 1'b0, 1'b0, 1'b0, dc, vc, ok, ix, bs, pk);
    checks++; if (dc !== 17) begin errors++; $display("FAIL bp_done_cycle got %0d required 17", dc); end
    checks++; if (vc !== 10) begin errors++; $display("FAIL bp_row_valid_cycles got %0d required 10", vc); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_row_addr got bad sequence required hold at 2"); end
    checks++; if ({ix, bs} !== {3'd0, 13'd80}) begin errors++; $display("FAIL bp_result got idx=%0d sad=%0d required 0/80", ix, bs); end
  endtask

  task automatic test_ties_latency();
    int dc, vc; logic ok, pk; logic [2:0] ix; logic [12:0] bs;
    run_search(pack6(50, 40, 40, 60, 40, 99), 3, -1, -1, -1, -1, -1, 1'b0, 1'b0, 1'b0, dc, vc, ok, ix, bs, pk);
    checks++; if (dc !== 18) begin errors++; $display("FAIL ties_done_cycle got %0d required 18", dc); end
    checks++; if (ix !== 3'd1) begin errors++; $display("FAIL ties_idx got %0d required 1", ix); end
    checks++; if (bs !== 13'd320) begin errors++; $display("FAIL ties_sad got %0d required 320", bs); end
  endtask

  task automatic test_max_values();
    int dc, vc; logic ok, pk; logic [2:0] ix; logic [12:0] bs;
    run_search(pack6(1023, 1023, 1023, 1023, 1023, 1022), 0, -1, -1, -1, -1, -1, 1'b0, 1'b0, 1'b0, dc, vc, ok, ix, bs, pk);
    checks++; if (ix !== 3'd5) begin errors++; $display("FAIL max_idx got %0d required 5", ix); end
    checks++; if (bs !== 13'd8176) begin errors++; $display("FAIL max_sad got %0d required 8176", bs); end
  endtask

  task automatic test_ignored_inputs();
    int dc, vc; logic ok, pk; logic [2:0] ix; logic [12:0] bs;
    // Spurious SAD while idle, then a start pulse in FETCH and a SAD in CMP.
    @(negedge clk);
    sad_valid = 1'b1; sad_in = {6{10'd1023}};
    run_search(pack6(10, 11, 12, 13, 14, 15), 0, -1, -1, 3, 11, -1, 1'b0, 1'b0, 1'b0, dc, vc, ok, ix, bs, pk);
    checks++; if (dc !== 15) begin errors++; $display("FAIL ign_done_cycle got %0d required 15", dc); end
    checks++; if ({ix, bs} !== {3'd0, 13'd80}) begin errors++; $display("FAIL ign_result got idx=%0d sad=%0d required 0/80", ix, bs); end
    checks++; if (pk !== 1'b1) begin errors++; $display("FAIL ign_no_restart got %0b required idle after done", pk); end
  endtask

  task automatic test_back_to_back();
    int dc, vc; logic ok, pk; logic [2:0] ix; logic [12:0] bs;
    // First search holds start high during DONE, then starts again in the first idle cycle.
    run_search(pack6(30, 20, 25, 21, 20, 40), 0, -1, -1, -1, -1, -1, 1'b0, 1'b1, 1'b1, dc, vc, ok, ix, bs, pk);
    checks++; if ({ix, bs} !== {3'd1, 13'd160}) begin errors++; $display("FAIL b2b_first got idx=%0d sad=%0d required 1/160", ix, bs); end
    checks++; if (pk !== 1'b1) begin errors++; $display("FAIL b2b_start_in_done got %0b required ignored", pk); end
    run_search(pack6(9, 9, 9, 9, 9, 8), 0, -1, -1, -1, -1, -1, 1'b1, 1'b0, 1'b0, dc, vc, ok, ix, bs, pk);
    checks++; if (dc !== 15) begin errors++; $display("FAIL b2b_second_done got %0d required 15", dc); end
    checks++; if ({ix, bs} !== {3'd5, 13'd64}) begin errors++; $display("FAIL b2b_second got idx=%0d sad=%0d required 5/64", ix, bs); end
  endtask

  task automatic test_reset_mid_search();
    int dc, vc; logic ok, pk; logic [2:0] ix; logic [12:0] bs;
    // Abort in WAIT after five SADs have been accumulated.
    run_search(pack6(1, 2, 3, 4, 5, 6), 3, -1, -1, -1, -1, 9, 1'b0, 1'b0, 1'b0, dc, vc, ok, ix, bs, pk);
    sad_valid = 1'b0; sad_in = 60'd0; start = 1'b0;
    #1;
    checks++;
    if ({row_valid, row_addr, busy, done, best_idx, best_sad} !== 22'd0) begin
      errors++; $display("FAIL mid_reset outputs=%h required 0", {row_valid, row_addr, busy, done, best_idx, best_sad});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_idle busy=%0b required 0", busy); end
    run_search(pack6(7, 6, 5, 4, 3, 2), 1, -1, -1, -1, -1, -1, 1'b0, 1'b0, 1'b0, dc, vc, ok, ix, bs, pk);
    checks++; if (dc !== 16) begin errors++; $display("FAIL mid_fresh_done got %0d required 16", dc); end
    checks++; if ({ix, bs} !== {3'd5, 13'd16}) begin errors++; $display("FAIL mid_fresh_result got idx=%0d sad=%0d required 5/16", ix, bs); end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_ties_latency();
    test_max_values();
    test_ignored_inputs();
    test_back_to_back();
    test_reset_mid_search();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
